// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
//
// Single-clock FIFO with a configurable width, any depth of 2 or more (not
// limited to powers of two), and programmable almost-full / almost-empty
// thresholds. Read data is registered, so data_out shows a word one cycle
// after the read that was accepted. Write acknowledge, overflow and underflow
// are also registered. The four occupancy flags are combinational decodes of
// the occupancy register.
//
// Optional feature (compile-time macro):
//   FIFO_COUNT_EN  - when defined, adds the data_count output, which shows
//                    the current occupancy. When undefined, the port does not
//                    exist and all other behaviour is the same.
//
// Parameters:
//   FIFO_WIDTH      data word width in bits (>=1)
//   FIFO_DEPTH      number of storage entries (>=2)
//   ALMOST_FULL_TH  occupancy at or above which almostfull asserts (not when full)
//   ALMOST_EMPTY_TH occupancy at or below which almostempty asserts (not when empty)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   data_in      in   write data
//   wr_en        in   write request
//   rd_en        in   read request
//   clr          in   synchronous flush; overrides wr_en/rd_en
//   data_out     out  registered read data; holds when no read is accepted
//   wr_ack       out  previous edge accepted a write
//   overflow     out  previous edge rejected a write because the FIFO was full
//   underflow    out  previous edge saw a read request while the FIFO was empty
//   full         out  occupancy == FIFO_DEPTH
//   empty        out  occupancy == 0
//   almostfull   out  occupancy >= ALMOST_FULL_TH and not full
//   almostempty  out  occupancy <= ALMOST_EMPTY_TH and not empty
//   data_count   out  occupancy (only with FIFO_COUNT_EN)
// -----------------------------------------------------------------------------
module param_sync_fifo #(
  parameter int FIFO_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 1,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [FIFO_WIDTH-1:0]                 data_in,
  input  logic                                  wr_en,
  input  logic                                  rd_en,
  input  logic                                  clr,
  output logic [FIFO_WIDTH-1:0]                 data_out,
  output logic                                  wr_ack,
  output logic                                  overflow,
  output logic                                  underflow,
  output logic                                  full,
  output logic                                  empty,
  output logic                                  almostfull,
  output logic                                  almostempty
`ifdef FIFO_COUNT_EN
  ,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       data_count
`endif
);

  // Pointers only need to address FIFO_DEPTH entries. The occupancy counter
  // must also be able to hold FIFO_DEPTH itself, so it can be one bit wider.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [FIFO_WIDTH-1:0] word_t;

  localparam ptr_t LAST_IDX = ptr_t'(FIFO_DEPTH - 1);
  localparam cnt_t DEPTH_C  = cnt_t'(FIFO_DEPTH);
  localparam cnt_t AF_TH_C  = cnt_t'(ALMOST_FULL_TH);
  localparam cnt_t AE_TH_C  = cnt_t'(ALMOST_EMPTY_TH);

  // Storage
  word_t mem [FIFO_DEPTH];

  // State registers
  ptr_t  wr_ptr_q,    wr_ptr_d;
  ptr_t  rd_ptr_q,    rd_ptr_d;
  cnt_t  count_q,     count_d;
  word_t data_out_q,  data_out_d;
  logic  wr_ack_q,    wr_ack_d;
  logic  overflow_q,  overflow_d;
  logic  underflow_q, underflow_d;

  // Accepted operations for this edge
  logic wr_accept;
  logic rd_accept;

  // Advance a pointer by one and wrap explicitly at the last entry. A
  // non-power-of-two depth cannot rely on natural binary rollover.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_IDX) ? '0 : p + ptr_t'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Occupancy flags: pure decodes of the occupancy register
  // ---------------------------------------------------------------------------
  always_comb begin
    full        = (count_q == DEPTH_C);
    empty       = (count_q == '0);
    almostfull  = (count_q >= AF_TH_C) && !full;
    almostempty = (count_q <= AE_TH_C) && !empty;
  end

  // ---------------------------------------------------------------------------
  // Accept decisions.
  // When the FIFO is full and both requests are high, only the read happens.
  // The write is rejected because it looks at the current full flag, not at
  // the space the read will free.
  // When the FIFO is empty and both requests are high, only the write happens.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_accept = wr_en && !clr && !full;
    rd_accept = rd_en && !clr && !empty;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default value first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (clr) begin
      // Flush: drop all stored words but keep the last word shown on data_out.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_accept) begin
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        data_out_d = mem[rd_ptr_q];
      end

      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase

      wr_ack_d = wr_accept;
      // When full is high, a write request can never be accepted.
      overflow_d  = wr_en && full;
      // An empty FIFO reports underflow even when a write happens on the same edge.
      underflow_d = rd_en && empty;
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the data array is deliberately not reset. After reset or clr, the
  // pointers and occupancy make every old entry unreachable, and a word is
  // only read after it has been written again.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_out  = data_out_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef FIFO_COUNT_EN
  assign data_count = count_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_sync_fifo
//
// Runs two FIFOs side by side from the same stimulus:
//   lane[0]: default parameters (depth 8, almost-full 7, almost-empty 1)
//   lane[1]: depth 6, almost-full 4, almost-empty 2
// Each lane has a queue-based reference model. A single compare process checks
// both lanes against their models on every falling edge. Directed literal
// checks pin the expected values at key points. data_count is checked when
// FIFO_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_param_sync_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic        clr;
  logic        chk_en;

  int vectors     = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // One lane per configuration: DUT plus its reference model
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D  = (g == 0) ? 8 : 6;
    localparam int CW = $clog2(D + 1);

    logic [15:0] dout;
    logic        ack, ovf, udf, fl, em, afl, ael;
`ifdef FIFO_COUNT_EN
    logic [CW-1:0] cnt;
`endif

    if (g == 0) begin : u_def
      param_sync_fifo u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .clr         (clr),
        .data_out    (dout),
        .wr_ack      (ack),
        .overflow    (ovf),
        .underflow   (udf),
        .full        (fl),
        .empty       (em),
        .almostfull  (afl),
        .almostempty (ael)
`ifdef FIFO_COUNT_EN
        ,
        .data_count  (cnt)
`endif
      );
    end else begin : u_cfg
      param_sync_fifo #(
        .FIFO_WIDTH      (16),
        .FIFO_DEPTH      (6),
        .ALMOST_FULL_TH  (4),
        .ALMOST_EMPTY_TH (2)
      ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .clr         (clr),
        .data_out    (dout),
        .wr_ack      (ack),
        .overflow    (ovf),
        .underflow   (udf),
        .full        (fl),
        .empty       (em),
        .almostfull  (afl),
        .almostempty (ael)
`ifdef FIFO_COUNT_EN
        ,
        .data_count  (cnt)
`endif
      );
    end

    // Reference model: a queue of stored words plus the registered outputs
    logic [15:0] mq [$];
    logic [15:0] m_dout;
    logic        m_ack, m_ovf, m_udf;
    int          m_n;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mq.delete();
        m_dout <= 16'h0;
        m_ack  <= 1'b0;
        m_ovf  <= 1'b0;
        m_udf  <= 1'b0;
        m_n    <= 0;
      end else begin
        automatic int   n     = mq.size();
        automatic logic wr_ok = wr_en && (n != D);
        automatic logic rd_ok = rd_en && (n != 0);
        if (clr) begin
          mq.delete();
          m_ack <= 1'b0;
          m_ovf <= 1'b0;
          m_udf <= 1'b0;
          m_n   <= 0;
        end else begin
          if (rd_ok) m_dout <= mq.pop_front();
          if (wr_ok) mq.push_back(data_in);
          m_ack <= wr_ok;
          m_ovf <= wr_en && (n == D);
          m_udf <= rd_en && (n == 0);
          m_n   <= n + int'(wr_ok) - int'(rd_ok);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_lane(input string ln, input int n, input int d, input int af, input int ae,
                          input logic [15:0] m_dout, input logic m_ack, input logic m_ovf,
                          input logic m_udf, input logic [15:0] dout, input logic ack,
                          input logic ovf, input logic udf, input logic fl, input logic em,
                          input logic afl, input logic ael);
    check({ln, ".data_out"},    32'(dout), 32'(m_dout));
    check({ln, ".wr_ack"},      32'(ack),  32'(m_ack));
    check({ln, ".overflow"},    32'(ovf),  32'(m_ovf));
    check({ln, ".underflow"},   32'(udf),  32'(m_udf));
    check({ln, ".full"},        32'(fl),   32'(n == d));
    check({ln, ".empty"},       32'(em),   32'(n == 0));
    check({ln, ".almostfull"},  32'(afl),  32'((n >= af) && (n != d)));
    check({ln, ".almostempty"}, 32'(ael),  32'((n <= ae) && (n != 0)));
  endtask

  // Single compare process covering both lanes on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_lane("L0", lane[0].m_n, 8, 7, 1, lane[0].m_dout, lane[0].m_ack, lane[0].m_ovf,
               lane[0].m_udf, lane[0].dout, lane[0].ack, lane[0].ovf, lane[0].udf,
               lane[0].fl, lane[0].em, lane[0].afl, lane[0].ael);
      cmp_lane("L1", lane[1].m_n, 6, 4, 2, lane[1].m_dout, lane[1].m_ack, lane[1].m_ovf,
               lane[1].m_udf, lane[1].dout, lane[1].ack, lane[1].ovf, lane[1].udf,
               lane[1].fl, lane[1].em, lane[1].afl, lane[1].ael);
`ifdef FIFO_COUNT_EN
      check("L0.data_count", 32'(lane[0].cnt), 32'(lane[0].m_n));
      check("L1.data_count", 32'(lane[1].cnt), 32'(lane[1].m_n));
`endif
    end
  end

  // Drive one cycle of inputs at a falling edge, then return at the next falling edge
  task automatic step(input logic w, input logic r, input logic c, input logic [15:0] d);
    wr_en   = w;
    rd_en   = r;
    clr     = c;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // ---------------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr     = 1'b0;
    data_in = 16'h0;
    chk_en  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.empty",       32'(lane[0].em),   32'd1);
    check("rst.almostempty", 32'(lane[0].ael),  32'd0);
    check("rst.full",        32'(lane[0].fl),   32'd0);
    check("rst.almostfull",  32'(lane[0].afl),  32'd0);
    check("rst.data_out",    32'(lane[0].dout), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Write 1..8. Lane 0 fills at 8; lane 1 fills at 6 and then overflows.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'(i));
      check("fill.wr_ack", 32'(lane[0].ack), 32'd1);
      if (i == 7) begin
        check("fill7.almostfull", 32'(lane[0].afl), 32'd1);
        check("fill7.full",       32'(lane[0].fl),  32'd0);
      end
      if (i == 8) begin
        check("fill8.full",       32'(lane[0].fl),  32'd1);
        check("fill8.almostfull", 32'(lane[0].afl), 32'd0);
      end
      if (i == 1 || i == 2) check("l1.ae_low", 32'(lane[1].ael), 32'd1);
      if (i == 3)           check("l1.ae_off", 32'(lane[1].ael), 32'd0);
      if (i == 4)           check("l1.af_on",  32'(lane[1].afl), 32'd1);
      if (i == 6)           check("l1.full",   32'(lane[1].fl),  32'd1);
      if (i == 7) begin
        check("l1.overflow", 32'(lane[1].ovf), 32'd1);
        check("l1.ovf_ack",  32'(lane[1].ack), 32'd0);
      end
    end

    // Write to a full FIFO: overflow is raised and the word is dropped
    step(1'b1, 1'b0, 1'b0, 16'hBEEF);
    check("ovf.overflow", 32'(lane[0].ovf), 32'd1);
    check("ovf.wr_ack",   32'(lane[0].ack), 32'd0);
    check("ovf.full",     32'(lane[0].fl),  32'd1);

    // Drain in order. Lane 1 returns 1..6, then holds 6 and reports underflow.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("drain.data_out", 32'(lane[0].dout), 32'(i));
      if (i <= 6) check("l1.drain", 32'(lane[1].dout), 32'(i));
      if (i == 7) begin
        check("l1.udf",      32'(lane[1].udf),  32'd1);
        check("l1.udf_hold", 32'(lane[1].dout), 32'd6);
      end
    end

    // Read from an empty FIFO
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("udf.underflow", 32'(lane[0].udf),  32'd1);
    check("udf.data_out",  32'(lane[0].dout), 32'h8);

    // Both requests while empty: only the write happens
    step(1'b1, 1'b1, 1'b0, 16'h0100);
    check("emp_both.wr_ack",      32'(lane[0].ack),  32'd1);
    check("emp_both.almostempty", 32'(lane[0].ael),  32'd1);
    check("emp_both.empty",       32'(lane[0].em),   32'd0);
    check("emp_both.data_out",    32'(lane[0].dout), 32'h8);

    // Bring occupancy to 4, then run 12 cycles with both requests high
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h0100 + i));
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, 1'b0, 16'(16'h0200 + k));
      check("both.data_out", 32'(lane[0].dout),
            (k < 4) ? 32'(16'h0100 + k) : 32'(16'h0200 + k - 4));
      check("both.wr_ack",   32'(lane[0].ack), 32'd1);
      check("l1.both_af",    32'(lane[1].afl), 32'd1);
    end

    // Occupancy 5, then clr together with a write
    step(1'b1, 1'b0, 1'b0, 16'h0300);
    step(1'b1, 1'b0, 1'b1, 16'h0400);
    check("clr.empty",    32'(lane[0].em),   32'd1);
    check("clr.wr_ack",   32'(lane[0].ack),  32'd0);
    check("clr.data_out", 32'(lane[0].dout), 32'h0207);

    // Asynchronous reset pulse between edges during a write burst
    step(1'b1, 1'b0, 1'b0, 16'h0500);
    step(1'b1, 1'b0, 1'b0, 16'h0501);
    #2 rst_n = 1'b0;
    #1;
    check("arst.empty",    32'(lane[0].em),   32'd1);
    check("arst.almostempty", 32'(lane[0].ael), 32'd0);
    check("arst.wr_ack",   32'(lane[0].ack),  32'd0);
    check("arst.data_out", 32'(lane[0].dout), 32'd0);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'h0600);
    step(1'b1, 1'b0, 1'b0, 16'h0601);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("post_rst.first", 32'(lane[0].dout), 32'h0600);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("post_rst.second", 32'(lane[0].dout), 32'h0601);
    step(1'b0, 1'b0, 1'b0, 16'h0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
